// File: rtl/jt6295_pkg.sv
// Shared constants and FSM encoding for the jt6295 CPU command sequencer.
package jt6295_pkg;
  localparam int ADDR_W         = 18;
  localparam int CMD_PHRASE_BIT = 7;
  localparam int HDR_BYTES      = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PHRASE,
    ST_FETCH,
    ST_ISSUE
  } state_t;
endpackage

// File: rtl/jt6295_cmd_fifo.sv
// Synchronous show-ahead byte FIFO; a push on a full FIFO is discarded.
module jt6295_cmd_fifo #(
  parameter int QAW = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  logic [7:0]     mem [2**QAW];
  logic [QAW-1:0] wr_ptr, rd_ptr;
  logic [QAW:0]   cnt;
  logic           do_push, do_pop;

  assign full    = cnt == (QAW+1)'(2**QAW);
  assign empty   = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + QAW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + QAW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (QAW+1)'(1);
        2'b01:   cnt <= cnt - (QAW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/jt6295_cmd_seq.sv
// CPU command sequencer: queues CPU bytes, fetches phrase headers, and drives
// level start/stop requests to the channel serialiser.
//   state  | meaning
//   IDLE   | pop next byte: phrase select or stop mask
//   PHRASE | wait for channel mask / attenuation byte
//   FETCH  | read 6 header bytes from ROM
//   ISSUE  | validate header, raise start for idle channels
import jt6295_pkg::*;

module jt6295_cmd_seq #(
  parameter int QAW    = 2,
  parameter int HDR_AW = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wrn,
  input  logic [7:0]        din,
  output logic [HDR_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] stop_addr,
  output logic [3:0]        att,
  output logic [3:0]        start,
  output logic [3:0]        stop,
  input  logic [3:0]        busy,
  input  logic [3:0]        ack,
  output logic              ovf,
  output logic              hdr_err
);
  state_t            state;
  logic              wrn_q, wr_pend;
  logic [7:0]        wr_byte, q_byte;
  logic              q_full, q_empty, pop;
  logic [3:0]        stop_set;
  logic [6:0]        phrase;
  logic [3:0]        mask, att_l;
  logic [2:0]        k;
  logic              settle;
  logic [ADDR_W-1:0] hdr_start, hdr_stop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrn_q   <= 1'b1;
      wr_pend <= 1'b0;
      wr_byte <= '0;
      ovf     <= 1'b0;
    end else begin
      wrn_q   <= wrn;
      wr_pend <= wrn_q & ~wrn;
      if (wrn_q & ~wrn) wr_byte <= din;
      ovf     <= wr_pend & q_full;
    end
  end

  jt6295_cmd_fifo #(.QAW(QAW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_pend),
    .pop   (pop),
    .wdata (wr_byte),
    .rdata (q_byte),
    .full  (q_full),
    .empty (q_empty)
  );

  // Holding IDLE while any start is pending keeps the issued outputs stable.
  assign pop = ~q_empty & ((state == ST_IDLE && start == 4'd0) || state == ST_PHRASE);
  assign stop_set = (state == ST_IDLE && pop && !q_byte[CMD_PHRASE_BIT]) ? q_byte[6:3] : 4'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      phrase     <= '0;
      mask       <= '0;
      att_l      <= '0;
      k          <= '0;
      settle     <= 1'b0;
      hdr_start  <= '0;
      hdr_stop   <= '0;
      rom_addr   <= '0;
      rom_cs     <= 1'b0;
      start_addr <= '0;
      stop_addr  <= '0;
      att        <= '0;
      start      <= '0;
      stop       <= '0;
      hdr_err    <= 1'b0;
    end else begin
      hdr_err <= 1'b0;
      stop    <= (stop & busy) | stop_set;
      start   <= start & ~ack;
      case (state)
        ST_IDLE: begin
          if (pop && q_byte[CMD_PHRASE_BIT]) begin
            phrase <= q_byte[6:0];
            state  <= ST_PHRASE;
          end
        end
        ST_PHRASE: begin
          if (pop) begin
            mask  <= q_byte[7:4];
            att_l <= q_byte[3:0];
            if (q_byte[7:4] == 4'd0) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_FETCH;
              k        <= '0;
              rom_addr <= HDR_AW'({phrase, 3'd0});
              rom_cs   <= 1'b1;
              settle   <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // rom_ok may still refer to the previous address for one cycle
          if (settle) begin
            settle <= 1'b0;
          end else if (rom_ok) begin
            case (k)
              3'd0:    hdr_start[17:16] <= rom_data[1:0];
              3'd1:    hdr_start[15:8]  <= rom_data;
              3'd2:    hdr_start[7:0]   <= rom_data;
              3'd3:    hdr_stop[17:16]  <= rom_data[1:0];
              3'd4:    hdr_stop[15:8]   <= rom_data;
              default: hdr_stop[7:0]    <= rom_data;
            endcase
            if (k == 3'(HDR_BYTES-1)) begin
              rom_cs <= 1'b0;
              state  <= ST_ISSUE;
            end else begin
              k        <= k + 3'd1;
              rom_addr <= rom_addr + HDR_AW'(1);
              settle   <= 1'b1;
            end
          end
        end
        default: begin
          if (hdr_stop <= hdr_start) begin
            hdr_err <= 1'b1;
          end else begin
            start      <= mask & ~busy & ~stop;
            start_addr <= hdr_start;
            stop_addr  <= hdr_stop;
            att        <= att_l;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/jt6295_cmd_seq.md
Name: jt6295_cmd_seq

Overview:
- CPU command sequencer for the ADPCM player.
- Decodes the two-byte phrase-play and one-byte stop commands, queues CPU writes, fetches the 6-byte phrase header from the ROM header area, then issues start/stop requests to the channel serialiser with a level handshake.
- Sits between the CPU write port and the channel serialiser; it owns the low-priority ROM slot.

Parameters:
- QAW, 2: log2 of the command byte FIFO depth (4 entries).
- HDR_AW, 10: header ROM address width (128 phrases × 8 bytes).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- wrn  in  1  CPU write strobe, active low; a byte is captured on the falling edge (1→0 seen between consecutive clk)
- din  in  8  CPU data
- rom_addr  out  HDR_AW  header byte address
- rom_cs  out  1  header ROM request
- rom_data  in  8  header byte
- rom_ok  in  1  rom_data valid for the current rom_addr
- start_addr  out  18  phrase start address; stable while start≠0
- stop_addr  out  18  phrase stop address; stable while start≠0
- att  out  4  attenuation; stable while start≠0
- start  out  4  per-channel start request, level
- stop  out  4  per-channel stop request, level
- busy  in  4  channel playing
- ack  in  4  channel accepted its start
- ovf  out  1  one-cycle pulse: CPU byte dropped on a full FIFO
- hdr_err  out  1  one-cycle pulse: header rejected

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; phrase latch cleared. Reset is asynchronous, so an assertion mid-fetch or mid-handshake aborts and restarts cleanly.
- Write capture: wrn edge detect registered; the byte is pushed on the cycle after the falling edge.
  - If the FIFO is full, the byte is dropped and ovf pulses.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Command decode, FSM states: IDLE, PHRASE, FETCH, ISSUE.
  - IDLE pops one byte when the FIFO is non-empty.
    - din[7]=1: latch phrase=din[6:0] and go to PHRASE.
    - din[7]=0: set stop[i] for each set bit din[6:3] (bit 3 maps to ch0), stay in IDLE.
  - PHRASE waits for the next popped byte.
    - mask=byte[7:4], att=byte[3:0].
    - If mask==0, return to IDLE with no ROM access.
    - Otherwise go to FETCH with byte index k=0.
- FETCH:
  - rom_addr={phrase,3'd0}+k; rom_cs=1.
  - rom_ok is ignored in the first cycle after rom_addr changes; it is accepted from the second cycle on.
  - Bytes k=0..2 form start address {b0[1:0],b1,b2}; bytes k=3..5 form stop address the same way. Bits b0[7:2] and b3[7:2] are ignored.
  - After k=5 is accepted: rom_cs=0, go to ISSUE.
  - No timeout; the FSM waits on rom_ok indefinitely.
- ISSUE, taking one cycle:
  - If stop_addr≤start_addr: pulse hdr_err, leave start untouched, go to IDLE.
  - Otherwise: start ← mask & ~busy. Busy channels are silently skipped. Drive the new start_addr, stop_addr and att outputs. Go to IDLE.
- Start handshake:
  - start[i] clears on the cycle after ack[i]=1.
  - IDLE does not pop while start≠0, so the outputs stay stable until every requested channel has acked. Stop commands are held back in the same way.
- Stop handshake:
  - stop[i] is held until busy[i]=0, then clears.
  - Setting stop[i] while busy[i]=0 clears it on the next cycle.
- Start and stop in the same cycle for channel i: stop wins; start[i] is not set.

Decomposition:
- Shared package jt6295_pkg holds:
  - constants CMD_PHRASE_BIT=7 and HDR_BYTES=6
  - the FSM state encoding
  - ADDR_W=18
- Natural sub-module: jt6295_cmd_fifo, a synchronous byte FIFO, depth 2**QAW, with full, empty and simultaneous push/pop support.

Test Plan:
- Write 0x85 then 0x18; ROM header bytes at 0x028..0x02D = 00 10 00 00 20 00 → rom_addr steps 0x028..0x02D; start_addr=0x01000, stop_addr=0x02000, att=8, start=4'b0001 held until ack[0], then start=0.
- Same command with busy=4'b0001 and mask 0x3 → start=4'b0010 only.
- Header with stop==start → hdr_err pulses once; start stays 0; FSM back in IDLE (the next command is processed normally).
- Write 0x78 with busy=4'hF → stop=4'hF; drop busy[2] → stop[2] clears the cycle after; the others stay high.
- Write 6 bytes back-to-back during a stalled fetch (rom_ok=0) → ovf pulses on the 5th and 6th bytes; the first 4 bytes execute in order after rom_ok resumes.
- Drop rstn mid-FETCH at k=3 → all outputs 0 immediately; after release, a fresh 0x81/0x10 command fetches from 0x008.
